downconverter: RTL and testbench
================================

// Module: downconverter
// PURPOSE
//   Receive-side counterpart of the TX upconverter. Takes the oversampled I/Q
//   stream at OS samples per symbol (after the matched filter). Keeps one
//   sample per symbol at a programmable phase. Slices each kept sample to a
//   hard bit for the PRBS checker.
//   Sits between the RX matched filter and the BER/PRBS-check block.
// PARAMETERS
//   NB_DATA  8   width of signed I/Q input samples
//   OS       4   oversampling factor, samples per symbol (>=2)
//   NB_PHASE 2   width of phase select, >= clog2(OS)
//   NB_CNT   16  width of kept-symbol counter
// PORTS
//   i_clock          in   1         system clock, rising edge
//   i_reset          in   1         asynchronous reset, active-low
//   i_enable         in   1         input sample strobe; one I/Q sample per high cycle
//   i_phase          in   NB_PHASE  requested sampling phase, 0..OS-1
//   i_data_I         in   NB_DATA   signed I sample
//   i_data_Q         in   NB_DATA   signed Q sample
//   o_data_I         out  NB_DATA   kept (decimated) I sample
//   o_data_Q         out  NB_DATA   kept (decimated) Q sample
//   o_bit_I          out  1         I hard decision
//   o_bit_Q          out  1         Q hard decision
//   o_valid          out  1         one-cycle strobe, new symbol on outputs
//   o_phase_applied  out  NB_PHASE  phase currently in use
//   o_sym_count      out  NB_CNT    kept-symbol count, wraps
// BEHAVIOUR
//   - Reset (i_reset=0, async): every output, phase counter and phase register go to 0.
//     Reset mid-symbol drops o_valid immediately and restarts the count at phase 0.
//   - Phase counter cnt, range 0..OS-1:
//     - advances only on cycles with i_enable=1; wraps OS-1 -> 0;
//     - holds while i_enable=0.
//   - Capture: when i_enable=1 and cnt==phase_reg, on the next edge:
//     - o_data_I/Q <= i_data_I/Q;
//     - o_bit_I/Q <= sign bit (MSB) of the sample; bit 1 = negative, which
//       matches the TX mapping {bit,0..0};
//     - o_valid <= 1 for exactly one cycle; o_sym_count += 1 (mod 2^NB_CNT).
//     - Latency: 1 clock from the accepted sample to o_valid.
//   - All other cycles: o_valid=0; data, bits and count hold their values.
//   - Phase update: phase_reg loads i_phase only on a cycle with i_enable=1
//     and cnt==OS-1 (symbol boundary).
//     - Same-cycle capture compares against the OLD phase_reg.
//     - Result: exactly one capture per OS enabled samples, including across
//       phase changes. 0->OS-1 gives a gap of 2*OS-1 samples; OS-1->0 gives
//       back-to-back kept samples 1 sample apart.
//     - i_phase >= OS at the boundary is ignored; phase_reg keeps its value.
//   - o_phase_applied = phase_reg.
//   - No arithmetic on data; widths pass through unchanged.
// TESTING
//   1) Assert i_reset=0 mid-stream -> all outputs 0 at once; o_valid stays 0 while held.
//   2) OS=4, phase=0, enable=1, I=-64,0,0,0,+64,0,0,0 -> o_valid high on cycles 1 and 5;
//      o_data_I=-64 then +64; o_bit_I=1 then 0; o_sym_count=1 then 2.
//   3) OS=4, phase=2, Q ramp 0..11 -> o_data_Q=2,6,10; one valid per 4 samples.
//   4) Change i_phase 0->3 while cnt=1 -> o_phase_applied changes only after cnt=3.
//      Next capture comes 7 samples after the last one. Then 3->0 gives
//      captures 1 sample apart.
//   5) i_enable toggling 1,0,1,0 -> cnt and o_valid advance only on enabled
//      samples; outputs hold while gated.
//   6) OS=3, NB_PHASE=2, i_phase=3 at boundary -> ignored; phase stays at prior value.

Source files
------------

// File: rtl/downconverter_if.sv
// Sample-stream bundle between the RX matched filter, the downconverter and the PRBS checker.
interface downconverter_if #(
    parameter int unsigned NB_DATA  = 8,
    parameter int unsigned NB_PHASE = 2,
    parameter int unsigned NB_CNT   = 16
);
    logic                       i_enable;
    logic [NB_PHASE-1:0]        i_phase;
    logic signed [NB_DATA-1:0]  i_data_I;
    logic signed [NB_DATA-1:0]  i_data_Q;
    logic signed [NB_DATA-1:0]  o_data_I;
    logic signed [NB_DATA-1:0]  o_data_Q;
    logic                       o_bit_I;
    logic                       o_bit_Q;
    logic                       o_valid;
    logic [NB_PHASE-1:0]        o_phase_applied;
    logic [NB_CNT-1:0]          o_sym_count;

    modport master (
        output i_enable, i_phase, i_data_I, i_data_Q,
        input  o_data_I, o_data_Q, o_bit_I, o_bit_Q, o_valid, o_phase_applied, o_sym_count
    );

    modport slave (
        input  i_enable, i_phase, i_data_I, i_data_Q,
        output o_data_I, o_data_Q, o_bit_I, o_bit_Q, o_valid, o_phase_applied, o_sym_count
    );
endinterface

// File: rtl/downconverter.sv
// Symbol-rate decimator: keeps one of every OS I/Q samples at a programmable
// phase and slices the kept sample to hard bits for the PRBS checker.
module downconverter #(
    parameter int unsigned NB_DATA  = 8,
    parameter int unsigned OS       = 4,
    parameter int unsigned NB_PHASE = 2,
    parameter int unsigned NB_CNT   = 16
) (
    input logic              i_clock,
    input logic              i_reset,
    downconverter_if.slave   bus
);
    localparam logic [NB_PHASE-1:0] LAST_PHASE = NB_PHASE'(OS - 1);

    logic [NB_PHASE-1:0]       cnt;
    logic [NB_PHASE-1:0]       phase_reg;
    logic signed [NB_DATA-1:0] data_i_q;
    logic signed [NB_DATA-1:0] data_q_q;
    logic                      bit_i_q;
    logic                      bit_q_q;
    logic                      valid_q;
    logic [NB_CNT-1:0]         sym_count_q;

    logic capture_c;
    logic boundary_c;
    logic phase_ok_c;

    // Capture compares against the phase in force before any boundary reload.
    assign capture_c  = bus.i_enable && (cnt == phase_reg);
    assign boundary_c = bus.i_enable && (cnt == LAST_PHASE);
    assign phase_ok_c = 32'(bus.i_phase) < OS;

    // Phase counter and phase register, both updated only on enabled samples.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            cnt       <= '0;
            phase_reg <= '0;
        end else if (bus.i_enable) begin
            cnt <= boundary_c ? '0 : cnt + NB_PHASE'(1);
            if (boundary_c && phase_ok_c) begin
                phase_reg <= bus.i_phase;
            end
        end
    end

    // Kept-sample registers; hold between captures.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            data_i_q    <= '0;
            data_q_q    <= '0;
            bit_i_q     <= 1'b0;
            bit_q_q     <= 1'b0;
            valid_q     <= 1'b0;
            sym_count_q <= '0;
        end else begin
            valid_q <= capture_c;
            if (capture_c) begin
                data_i_q    <= bus.i_data_I;
                data_q_q    <= bus.i_data_Q;
                bit_i_q     <= bus.i_data_I[NB_DATA-1];
                bit_q_q     <= bus.i_data_Q[NB_DATA-1];
                sym_count_q <= sym_count_q + NB_CNT'(1);
            end
        end
    end

    assign bus.o_data_I        = data_i_q;
    assign bus.o_data_Q        = data_q_q;
    assign bus.o_bit_I         = bit_i_q;
    assign bus.o_bit_Q         = bit_q_q;
    assign bus.o_valid         = valid_q;
    assign bus.o_phase_applied = phase_reg;
    assign bus.o_sym_count     = sym_count_q;
endmodule

// File: tb/tb_downconverter.sv
// Scoreboard bench for downconverter: directed vectors push expected symbols,
// per-instance monitors pop and compare on o_valid (OS=4 and OS=3 instances).
module tb_downconverter;
    localparam int unsigned NB_DATA  = 8;
    localparam int unsigned NB_PHASE = 2;
    localparam int unsigned NB_CNT   = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    downconverter_if #(.NB_DATA(NB_DATA), .NB_PHASE(NB_PHASE), .NB_CNT(NB_CNT)) bus4 ();
    downconverter_if #(.NB_DATA(NB_DATA), .NB_PHASE(NB_PHASE), .NB_CNT(NB_CNT)) bus3 ();

    downconverter #(.NB_DATA(NB_DATA), .OS(4), .NB_PHASE(NB_PHASE), .NB_CNT(NB_CNT)) dut4 (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus4.slave)
    );

    downconverter #(.NB_DATA(NB_DATA), .OS(3), .NB_PHASE(NB_PHASE), .NB_CNT(NB_CNT)) dut3 (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus3.slave)
    );

    typedef struct {
        logic signed [NB_DATA-1:0] di;
        logic signed [NB_DATA-1:0] dq;
        logic [NB_CNT-1:0]         cnt;
        logic [NB_PHASE-1:0]       ph;
    } exp_t;

    exp_t q4[$];
    exp_t q3[$];
    exp_t e4;
    exp_t e3;
    logic [NB_CNT-1:0] cnt4 = '0;
    logic [NB_CNT-1:0] cnt3 = '0;
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    // OS=4 monitor
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus4.o_valid === 1'b1) begin
            if (q4.size() == 0) begin
                chk("os4_unexpected_valid", 32'(q4.size()), 32'd1);
            end else begin
                e4 = q4.pop_front();
                chk("os4_data_I", 32'(bus4.o_data_I), 32'(e4.di));
                chk("os4_data_Q", 32'(bus4.o_data_Q), 32'(e4.dq));
                chk("os4_bit_I", 32'(bus4.o_bit_I), 32'(e4.di < 0));
                chk("os4_bit_Q", 32'(bus4.o_bit_Q), 32'(e4.dq < 0));
                chk("os4_sym_count", 32'(bus4.o_sym_count), 32'(e4.cnt));
                chk("os4_phase_applied", 32'(bus4.o_phase_applied), 32'(e4.ph));
            end
        end
    end

    // OS=3 monitor
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus3.o_valid === 1'b1) begin
            if (q3.size() == 0) begin
                chk("os3_unexpected_valid", 32'(q3.size()), 32'd1);
            end else begin
                e3 = q3.pop_front();
                chk("os3_data_I", 32'(bus3.o_data_I), 32'(e3.di));
                chk("os3_data_Q", 32'(bus3.o_data_Q), 32'(e3.dq));
                chk("os3_bit_I", 32'(bus3.o_bit_I), 32'(e3.di < 0));
                chk("os3_bit_Q", 32'(bus3.o_bit_Q), 32'(e3.dq < 0));
                chk("os3_sym_count", 32'(bus3.o_sym_count), 32'(e3.cnt));
                chk("os3_phase_applied", 32'(bus3.o_phase_applied), 32'(e3.ph));
            end
        end
    end

    task automatic step4(input logic en, input logic [1:0] ph, input int di, input int dq,
                         input bit keep, input logic [1:0] eph);
        exp_t e;
        bus4.i_enable = en;
        bus4.i_phase  = ph;
        bus4.i_data_I = NB_DATA'(di);
        bus4.i_data_Q = NB_DATA'(dq);
        if (keep) begin
            cnt4++;
            e.di = NB_DATA'(di); e.dq = NB_DATA'(dq); e.cnt = cnt4; e.ph = eph;
            q4.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step3(input logic en, input logic [1:0] ph, input int di, input int dq,
                         input bit keep, input logic [1:0] eph);
        exp_t e;
        bus3.i_enable = en;
        bus3.i_phase  = ph;
        bus3.i_data_I = NB_DATA'(di);
        bus3.i_data_Q = NB_DATA'(dq);
        if (keep) begin
            cnt3++;
            e.di = NB_DATA'(di); e.dq = NB_DATA'(dq); e.cnt = cnt3; e.ph = eph;
            q3.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset4(input string tag);
        chk({tag, "_valid"}, 32'(bus4.o_valid), 32'd0);
        chk({tag, "_data_I"}, 32'(bus4.o_data_I), 32'd0);
        chk({tag, "_data_Q"}, 32'(bus4.o_data_Q), 32'd0);
        chk({tag, "_bits"}, 32'({bus4.o_bit_I, bus4.o_bit_Q}), 32'd0);
        chk({tag, "_sym_count"}, 32'(bus4.o_sym_count), 32'd0);
        chk({tag, "_phase"}, 32'(bus4.o_phase_applied), 32'd0);
        chk({tag, "_os3_valid"}, 32'(bus3.o_valid), 32'd0);
        chk({tag, "_os3_count"}, 32'(bus3.o_sym_count), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    int t2i[8] = '{-64, 0, 0, 0, 64, 0, 0, 0};
    int t2q[8] = '{5, 0, 0, 0, -3, 0, 0, 0};
    int t5e[9] = '{1, 0, 1, 0, 1, 0, 1, 0, 1};
    int t5i[9] = '{-5, -99, 7, -99, 6, -99, 4, -99, -1};

    initial begin
        rst_n = 1'b0;
        bus4.i_enable = 1'b0; bus4.i_phase = '0; bus4.i_data_I = '0; bus4.i_data_Q = '0;
        bus3.i_enable = 1'b0; bus3.i_phase = '0; bus3.i_data_I = '0; bus3.i_data_Q = '0;
        #12;
        chk_reset4("por");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Phase 0 decimation; last boundary requests phase 2
        for (int k = 0; k < 8; k++) begin
            step4(1'b1, (k == 7) ? 2'd2 : 2'd0, t2i[k], t2q[k], (k == 0) || (k == 4), 2'd0);
        end

        // Phase 2, Q ramp 0..11; last boundary returns to phase 0
        for (int k = 0; k < 12; k++) begin
            step4(1'b1, (k == 11) ? 2'd0 : 2'd2, 0, k, (k % 4) == 2, 2'd2);
        end

        // Phase 0 -> 3 requested at cnt=1, then 3 -> 0
        for (int k = 0; k < 12; k++) begin
            step4(1'b1, (k >= 1 && k <= 6) ? 2'd3 : 2'd0, 10 + k, 0,
                  (k == 0) || (k == 7) || (k == 8), 2'd0);
            if (k == 2) chk("ph_before_boundary", 32'(bus4.o_phase_applied), 32'd0);
            if (k == 3) chk("ph_after_boundary", 32'(bus4.o_phase_applied), 32'd3);
            if (k == 6) chk("ph_held_3", 32'(bus4.o_phase_applied), 32'd3);
        end

        // Gated enable: only enabled samples advance
        for (int k = 0; k < 9; k++) begin
            step4(t5e[k] != 0, 2'd0, t5i[k], 3 * k - 10, (k == 0) || (k == 8), 2'd0);
            if (k == 1) begin
                chk("gate_valid_low", 32'(bus4.o_valid), 32'd0);
                chk("gate_hold_data_I", 32'(bus4.o_data_I), 32'(-5));
                chk("gate_hold_count", 32'(bus4.o_sym_count), 32'd9);
            end
        end

        // Mid-stream reset right as a symbol is presented
        for (int k = 0; k < 3; k++) step4(1'b1, 2'd0, 1, 1, 1'b0, 2'd0);
        step4(1'b1, 2'd0, 33, -7, 1'b0, 2'd0);
        chk("pre_reset_valid", 32'(bus4.o_valid), 32'd1);
        chk("pre_reset_data_I", 32'(bus4.o_data_I), 32'd33);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset4("mid");
        for (int k = 0; k < 2; k++) begin
            step4(1'b1, 2'd0, 50, 50, 1'b0, 2'd0);
            chk("held_reset_valid", 32'(bus4.o_valid), 32'd0);
        end
        rst_n = 1'b1;
        cnt4 = '0;
        cnt3 = '0;
        step4(1'b1, 2'd0, -128, 127, 1'b1, 2'd0);
        step4(1'b0, 2'd0, 0, 0, 1'b0, 2'd0);

        // OS=3: phase 1 accepted, out-of-range phase 3 ignored
        for (int k = 0; k < 11; k++) begin
            step3(1'b1, (k < 3) ? 2'd1 : 2'd3, k, -k - 1,
                  (k == 0) || (k >= 4 && (k % 3) == 1), (k == 0) ? 2'd0 : 2'd1);
            if (k == 5) chk("os3_ph_ignored_a", 32'(bus3.o_phase_applied), 32'd1);
            if (k == 8) chk("os3_ph_ignored_b", 32'(bus3.o_phase_applied), 32'd1);
        end
        step3(1'b0, 2'd0, 0, 0, 1'b0, 2'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("os4_queue_drained", 32'(q4.size()), 32'd0);
        chk("os3_queue_drained", 32'(q3.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
